// File: rtl/arm_pkg.sv
// Shared widths, fetch FSM encoding and the fetch-queue entry type.
package arm_pkg;
  localparam int ADDR_W     = 64;
  localparam int INSTR_W    = 32;
  localparam int PC_STEP    = 4;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low two bits are ignored.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return a & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory port, redirect input and decode handshake.
interface fetch_unit_if;
  import arm_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_ack, imem_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_ack, imem_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} queue; entry 0 is always the head so the output is a flop.
module fetch_fifo
  import arm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);
  fetch_entry_t r_ent0, r_ent1;
  logic [1:0]   r_count;
  logic         w_pop;

  assign w_pop   = i_pop & (r_count != 2'd0);
  assign o_head  = r_ent0;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_ent0  <= '0;
      r_ent1  <= '0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_ent0 <= i_data;
          else                 r_ent1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent0  <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever survives the pop.
          if (r_count == 2'd1) begin
            r_ent0 <= i_data;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requests feeding a 2-entry queue to decode.
module fetch_unit
  import arm_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);
  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [1:0]        w_count, w_cnt_after_pop;
  logic              w_valid, w_pop, w_push;
  fetch_entry_t      w_head, w_push_data;

  assign w_valid         = (w_count != 2'd0);
  assign w_pop           = w_valid & bus.out_ready;
  assign w_cnt_after_pop = w_count - {1'b0, w_pop};
  assign w_push_data     = '{pc: r_pc, instr: bus.imem_data};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.redirect || (w_cnt_after_pop < 2'd2)) w_state_nxt = REQ;
      end
      REQ: begin
        if (bus.imem_ack) begin
          w_push   = ~bus.redirect;
          w_pc_nxt = r_pc + ADDR_W'(PC_STEP);
          // Keep requesting only if the pushed word still leaves a free slot.
          w_state_nxt = (bus.redirect || (w_cnt_after_pop == 2'd0)) ? REQ : IDLE;
        end else if (bus.redirect) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        // Swallow the ack of the request that was in flight when redirected.
        if (bus.imem_ack) w_state_nxt = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (bus.redirect) w_pc_nxt = align_pc(bus.redirect_pc);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  fetch_fifo u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop & ~bus.redirect),
    .i_flush (bus.redirect),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.imem_req  = (r_state == REQ);
  assign bus.imem_addr = r_pc;
  assign bus.out_valid = w_valid;
  assign bus.out_pc    = w_head.pc;
  assign bus.out_instr = w_head.instr;
endmodule
